// File: rtl/matrix_uart_loader_if.sv
// Frame handshake between the UART loader and the downstream diagonal-sum matrix engine.
`timescale 1ns/1ps
interface matrix_uart_loader_if #(
   parameter int ELEMS = 4
);
   logic                 mat_valid;
   logic                 mat_ready;
   logic [8*ELEMS-1:0]   mat_data;

   modport master (output mat_valid, output mat_data, input mat_ready);
   modport slave  (input mat_valid, input mat_data, output mat_ready);
endinterface

// File: rtl/matrix_uart_loader.sv
// 8N1 UART receiver packing ELEMS bytes per frame into a double-buffered valid/ready output.
// Optional inter-byte timeout that discards partial frames: define LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module matrix_uart_loader #(
   parameter int CLK_FREQ_HZ  = 100000000,
   parameter int BAUD         = 115200,
   parameter int ELEMS        = 4,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                                     i_clock,
   input  logic                                     i_reset,
   input  logic                                     i_uart_rx,
   matrix_uart_loader_if.master                     mat_if,
   output logic [$clog2(ELEMS > 1 ? ELEMS : 2)-1:0] o_elem_cnt,
   output logic                                     o_frame_err,
   output logic                                     o_overrun,
   output logic                                     o_timeout
);

   // state   | meaning
   // S_IDLE  | line idle, waiting for a falling start edge
   // S_START | counting to mid start bit to reject glitches
   // S_DATA  | sampling 8 data bits LSB first, one per bit period
   // S_STOP  | sampling the stop bit; high accepts the byte

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int EW           = $clog2(ELEMS > 1 ? ELEMS : 2);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [EW-1:0] LAST_SLOT = EW'(ELEMS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_rx_prev;
   logic [CW-1:0]        r_bit_cnt;
   logic [2:0]           r_bit_idx;
   logic [7:0]           r_shift;
   logic [EW-1:0]        r_elem_cnt;
   logic [8*ELEMS-1:0]   r_asm;
   logic [8*ELEMS-1:0]   r_mat_data;
   logic                 r_mat_valid;
   logic                 r_overrun;
   logic                 r_frame_err;

   logic                 w_fall;
   logic                 w_tc;
   logic                 w_load_half;
   logic                 w_load_full;
   logic                 w_shift;
   logic                 w_byte_ok;
   logic                 w_stop_bad;
   logic                 w_frame_done;
   logic                 w_to_hit;
   logic [8*ELEMS-1:0]   w_frame;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_s    <= r_rx_meta;
         r_rx_prev <= r_rx_s;
      end
   end

   assign w_fall = r_rx_prev & ~r_rx_s;
   assign w_tc   = (r_bit_cnt == '0);

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_half = 1'b0;
      w_load_full = 1'b0;
      w_shift     = 1'b0;
      w_byte_ok   = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nxt = S_START;
               w_load_half = 1'b1;
            end
         end
         S_START: begin
            if (w_tc) begin
               if (!r_rx_s) begin
                  w_state_nxt = S_DATA;
                  w_load_full = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_tc) begin
               w_shift     = 1'b1;
               w_load_full = 1'b1;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_tc) begin
               w_state_nxt = S_IDLE;
               w_byte_ok   = r_rx_s;
               w_stop_bad  = ~r_rx_s;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bit timer: reload at the sample points, terminal count at zero.
   always_ff @(posedge i_clock) begin
      if (i_reset)          r_bit_cnt <= '0;
      else if (w_load_half) r_bit_cnt <= HALF_LOAD;
      else if (w_load_full) r_bit_cnt <= FULL_LOAD;
      else if (!w_tc)       r_bit_cnt <= r_bit_cnt - 1'b1;
   end

   // The bit index wraps 7 -> 0 on the last data bit, so it is ready for the next byte.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_shift) begin
         r_bit_idx <= r_bit_idx + 1'b1;
         r_shift   <= {r_rx_s, r_shift[7:1]};
      end
   end

   assign w_frame_done = w_byte_ok && (r_elem_cnt == LAST_SLOT);

   always_comb begin
      w_frame = r_asm;
      w_frame[8*(ELEMS-1) +: 8] = r_shift;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_elem_cnt <= '0;
         r_asm      <= '0;
      end else if (w_to_hit) begin
         r_elem_cnt <= '0;
      end else if (w_byte_ok) begin
         r_elem_cnt <= (r_elem_cnt == LAST_SLOT) ? '0 : r_elem_cnt + 1'b1;
         for (int k = 0; k < ELEMS; k++) begin
            if (r_elem_cnt == EW'(k)) r_asm[8*k +: 8] <= r_shift;
         end
      end
   end

   // Output buffer: a completed frame loads only if the buffer is free or draining this cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mat_valid <= 1'b0;
         r_mat_data  <= '0;
         r_overrun   <= 1'b0;
      end else if (w_frame_done && (!r_mat_valid || mat_if.mat_ready)) begin
         r_mat_valid <= 1'b1;
         r_mat_data  <= w_frame;
      end else begin
         if (w_frame_done)                    r_overrun   <= 1'b1;
         if (r_mat_valid && mat_if.mat_ready) r_mat_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_frame_err <= 1'b0;
      else         r_frame_err <= w_stop_bad;
   end

`ifdef LOADER_TIMEOUT_EN
   localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW     = $clog2(TO_CYC);
   localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);

   logic [TW-1:0] r_idle_cnt;
   logic          r_timeout;
   logic          w_idle_run;

   assign w_idle_run = (r_state == S_IDLE) && (r_elem_cnt != '0) && !w_fall;
   assign w_to_hit   = w_idle_run && (r_idle_cnt == '0);

   always_ff @(posedge i_clock) begin
      if (i_reset)                       r_idle_cnt <= TO_LOAD;
      else if (!w_idle_run || w_to_hit)  r_idle_cnt <= TO_LOAD;
      else                               r_idle_cnt <= r_idle_cnt - 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_timeout <= 1'b0;
      else         r_timeout <= w_to_hit;
   end

   assign o_timeout = r_timeout;
`else
   assign w_to_hit  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   assign mat_if.mat_valid = r_mat_valid;
   assign mat_if.mat_data  = r_mat_data;
   assign o_elem_cnt       = r_elem_cnt;
   assign o_frame_err      = r_frame_err;
   assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_matrix_uart_loader.sv
// Self-checking bench for matrix_uart_loader: vector table, directed corner cases, random traffic.
`timescale 1ns/1ps
module tb_matrix_uart_loader;
   localparam int CLK_NS = 10;
   localparam int CPB    = 48;
   localparam int BIT_NS = CPB * CLK_NS;
   localparam int ELEMS  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [1:0] elem_cnt;
   logic       ferr, ovr, tmo;

   matrix_uart_loader_if #(.ELEMS(ELEMS)) mif ();

   matrix_uart_loader #(
      .CLK_FREQ_HZ (48000000),
      .BAUD        (1000000),
      .ELEMS       (ELEMS),
      .TIMEOUT_BITS(20)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_uart_rx  (rx),
      .mat_if     (mif.master),
      .o_elem_cnt (elem_cnt),
      .o_frame_err(ferr),
      .o_overrun  (ovr),
      .o_timeout  (tmo)
   );

   always #(CLK_NS/2) clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ferr_cnt = 0;
   int          tmo_cnt  = 0;
   int          valid_cyc = 0;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   logic [7:0]  mdl_bytes[$];
   bit          rand_ready_en = 0;

   always @(negedge clk) begin
      if (ferr) ferr_cnt++;
      if (tmo) tmo_cnt++;
      if (mif.mat_valid) valid_cyc++;
      if (mif.mat_valid && mif.mat_ready) obs_q.push_back(mif.mat_data);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) mif.mat_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: every ELEMS good bytes form one frame, first byte in the low lane.
   task automatic model_push(input logic [7:0] b);
      logic [31:0] f;
      mdl_bytes.push_back(b);
      if (mdl_bytes.size() == ELEMS) begin
         f = '0;
         for (int k = 0; k < ELEMS; k++) f[8*k +: 8] = mdl_bytes[k];
         exp_q.push_back(f);
         mdl_bytes.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit stop_ok);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(BIT_NS);
      end
      rx = stop_ok;
      #(BIT_NS);
      rx = 1'b1;
      #(BIT_NS);
   endtask

   task automatic send_good(input logic [7:0] d);
      send_byte(d, 1'b1);
      model_push(d);
   endtask

   task automatic compare_frames(input string name);
      check({name, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check({name, "_frame"}, obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, mif.mat_valid, 0);
      check({name, "_data"}, mif.mat_data, 0);
      check({name, "_elem_cnt"}, elem_cnt, 0);
      check({name, "_frame_err"}, ferr, 0);
      check({name, "_overrun"}, ovr, 0);
      check({name, "_timeout"}, tmo, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx  = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      mdl_bytes.delete();
      repeat (4) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      logic [1:0] exp_cnt;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int f0, t0, nbad;
      logic [7:0] b;
      bit ok;

      vecs[0] = '{8'h01, 1'b1, 2'd1, 0};
      vecs[1] = '{8'h02, 1'b1, 2'd2, 0};
      vecs[2] = '{8'hA5, 1'b0, 2'd2, 1};
      vecs[3] = '{8'h03, 1'b1, 2'd3, 0};
      vecs[4] = '{8'h04, 1'b1, 2'd0, 0};
      vecs[5] = '{8'h5A, 1'b0, 2'd0, 1};
      vecs[6] = '{8'h10, 1'b1, 2'd1, 0};
      vecs[7] = '{8'h20, 1'b1, 2'd2, 0};
      vecs[8] = '{8'h30, 1'b1, 2'd3, 0};
      vecs[9] = '{8'h40, 1'b1, 2'd0, 0};

      mif.mat_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_all_zero("post_reset");
      valid_cyc = 0;

      // Table: good bytes, bad stop bits, slot reuse after a framing error.
      for (int i = 0; i < 10; i++) begin
         f0 = ferr_cnt;
         send_byte(vecs[i].data, vecs[i].stop_ok);
         if (vecs[i].stop_ok) model_push(vecs[i].data);
         check($sformatf("vec%0d_elem_cnt", i), elem_cnt, vecs[i].exp_cnt);
         check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
      end
      check("first_frame", obs_q.size() > 0 ? obs_q[0] : 32'hxxxxxxxx, 32'h04030201);
      check("valid_cycles", valid_cyc, 2);
      compare_frames("table");

      // Short low glitch must be ignored.
      send_good(8'h77);
      f0 = ferr_cnt;
      rx = 1'b0;
      #200;
      rx = 1'b1;
      #(2*BIT_NS);
      check("glitch_elem_cnt", elem_cnt, 1);
      check("glitch_frame_err", ferr_cnt - f0, 0);
      send_good(8'h88);
      send_good(8'h99);
      send_good(8'hAA);
      compare_frames("glitch");

      // Back-pressure: second frame dropped, overrun sticky.
      @(negedge clk);
      mif.mat_ready = 1'b0;
      send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
      check("bp_valid1", mif.mat_valid, 1);
      check("bp_data1", mif.mat_data, 32'h04030201);
      check("bp_overrun1", ovr, 0);
      send_byte(8'h05, 1); send_byte(8'h06, 1); send_byte(8'h07, 1); send_byte(8'h08, 1);
      check("bp_valid2", mif.mat_valid, 1);
      check("bp_data2", mif.mat_data, 32'h04030201);
      check("bp_overrun2", ovr, 1);
      check("bp_elem_cnt", elem_cnt, 0);
      @(negedge clk);
      mif.mat_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("bp_valid_after", mif.mat_valid, 0);
      check("bp_transfers", obs_q.size(), 1);
      check("bp_xfer_data", obs_q.size() > 0 ? obs_q[0] : 32'hxxxxxxxx, 32'h04030201);
      check("bp_overrun_sticky", ovr, 1);
      obs_q.delete();

      // Reset in the middle of byte 3.
      send_byte(8'h01, 1);
      send_byte(8'h02, 1);
      rx = 1'b0; #(BIT_NS);
      rx = 1'b1; #(BIT_NS);
      rx = 1'b0; #(BIT_NS/2);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("midbyte_reset");
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #(2*BIT_NS);
      check_all_zero("after_midbyte_reset");
      obs_q.delete();
      mdl_bytes.delete();
      send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
      compare_frames("reset_recover");

      // Random traffic with random ready, framing errors and glitches.
      rand_ready_en = 1;
      nbad = 0;
      f0 = ferr_cnt;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            rx = 1'b0;
            #($urandom_range(30, 200));
            rx = 1'b1;
            #(BIT_NS);
         end
         b  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         send_byte(b, ok);
         if (ok) model_push(b);
         else nbad++;
         #($urandom_range(0, 3) * 7);
      end
      repeat (60) @(negedge clk);
      rand_ready_en = 0;
      #2;
      mif.mat_ready = 1'b1;
      repeat (3) @(negedge clk);
      compare_frames("random");
      check("random_elem_cnt", elem_cnt, mdl_bytes.size());
      check("random_frame_err", ferr_cnt - f0, nbad);
      check("random_overrun", ovr, 0);

`ifdef LOADER_TIMEOUT_EN
      do_reset();
      obs_q.delete();
      send_good(8'h11);
      send_good(8'h22);
      check("to_elem_cnt_before", elem_cnt, 2);
      t0 = tmo_cnt;
      #(25*BIT_NS);
      check("to_pulse", tmo_cnt - t0, 1);
      check("to_elem_cnt_after", elem_cnt, 0);
      mdl_bytes.delete();
      send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
      compare_frames("to_recover");
`else
      t0 = 0;
      check("timeout_never", tmo_cnt, t0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
